sequenciador_polinomio: RTL

Host-side initiator for the polynomial datapath/controller block (`projeto`, which computes Resultado = A·X² + B·X + C). It sweeps X over a programmed range and runs one inicio/LED/pronto handshake per point. Each returned Resultado goes into a small result buffer readable by the surrounding system. It sits between the system control logic and `projeto`, replacing the hand-driven inicio/pronto stimulus.

---
 rtl/sequenciador_polinomio_pkg.sv | 17 +
 rtl/sequenciador_polinomio_banco_resultados.sv | 26 ++
 rtl/sequenciador_polinomio.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sequenciador_polinomio_pkg.sv
// Shared definitions for the polynomial sweep initiator: controller states
// and default sizing constants.
package sequenciador_pkg;

  localparam int W_PADRAO       = 16;
  localparam int TIMEOUT_PADRAO = 64;

  typedef enum logic [2:0] {
    OCIOSO,
    INICIA,
    ESPERA,
    LIBERA,
    FIM,
    ERRO
  } estado_t;

endpackage

// File: rtl/sequenciador_polinomio_banco_resultados.sv
// Result buffer: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; validity is tracked by the caller.
module banco_resultados #(
  parameter  int W        = 16,
  parameter  int N_PONTOS = 8,
  localparam int AW       = $clog2(N_PONTOS)
) (
  input  logic          ck,
  input  logic          i_escreve,
  input  logic [AW-1:0] i_end_escrita,
  input  logic [W-1:0]  i_dado,
  input  logic [AW-1:0] i_end_leitura,
  output logic [W-1:0]  o_dado
);

  logic [W-1:0] r_mem [N_PONTOS];

  always_ff @(posedge ck) begin
    if (i_escreve) begin
      r_mem[i_end_escrita] <= i_dado;
    end
  end

  assign o_dado = r_mem[i_end_leitura];

endmodule

// File: rtl/sequenciador_polinomio.sv
// Sweeps X over a programmed range, running one inicio/LED/pronto handshake
// with the polynomial block per point and storing each Resultado.
module sequenciador_polinomio
  import sequenciador_pkg::*;
#(
  parameter  int W        = W_PADRAO,
  parameter  int N_PONTOS = 8,
  parameter  int TIMEOUT  = TIMEOUT_PADRAO,
  localparam int AW       = $clog2(N_PONTOS),
  localparam int CW       = AW + 1,
  localparam int TW       = $clog2(TIMEOUT + 1)
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          partida,
  input  logic [W-1:0]  X0,
  input  logic [W-1:0]  passo,
  input  logic [W-1:0]  A_in,
  input  logic [W-1:0]  B_in,
  input  logic [W-1:0]  C_in,
  input  logic [CW-1:0] quantidade,
  output logic          inicio,
  output logic          pronto,
  output logic [W-1:0]  X,
  output logic [W-1:0]  A,
  output logic [W-1:0]  B,
  output logic [W-1:0]  C,
  input  logic [W-1:0]  Resultado,
  input  logic          LED,
  output logic          ocupado,
  output logic          concluido,
  output logic          erro,
  output logic [CW-1:0] contagem,
  input  logic [AW-1:0] indice_leitura,
  output logic [W-1:0]  dado_leitura
);

  estado_t       r_estado;
  logic          r_inicio;
  logic          r_pronto;
  logic          r_ocupado;
  logic          r_concluido;
  logic          r_erro;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_c;
  logic [CW-1:0] r_limite;
  logic [CW-1:0] r_contagem;
  logic [TW-1:0] r_tempo;

  logic [CW-1:0] w_limite_ent;
  logic [CW-1:0] w_contagem_inc;
  logic          w_ultimo;
  logic          w_tempo_esgotado;
  logic          w_escreve;
  logic [W-1:0]  w_dado_banco;

  // Requests beyond the buffer depth are clipped rather than wrapping over old results.
  assign w_limite_ent     = (quantidade > CW'(N_PONTOS)) ? CW'(N_PONTOS) : quantidade;
  assign w_contagem_inc   = r_contagem + CW'(1);
  assign w_ultimo         = (w_contagem_inc == r_limite);
  assign w_tempo_esgotado = (r_tempo == TW'(TIMEOUT));
  assign w_escreve        = (r_estado == ESPERA) && LED;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_estado    <= OCIOSO;
      r_inicio    <= 1'b0;
      r_pronto    <= 1'b0;
      r_ocupado   <= 1'b0;
      r_concluido <= 1'b0;
      r_erro      <= 1'b0;
      r_x         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_limite    <= '0;
      r_contagem  <= '0;
      r_tempo     <= '0;
    end else begin
      r_inicio    <= 1'b0;
      r_concluido <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (partida) begin
            r_x        <= X0;
            r_a        <= A_in;
            r_b        <= B_in;
            r_c        <= C_in;
            r_limite   <= w_limite_ent;
            r_contagem <= '0;
            r_erro     <= 1'b0;
            r_ocupado  <= 1'b1;
            if (w_limite_ent == '0) begin
              r_estado    <= FIM;
              r_concluido <= 1'b1;
            end else begin
              r_estado <= INICIA;
              r_inicio <= 1'b1;
            end
          end
        end
        INICIA: begin
          r_estado <= ESPERA;
          r_tempo  <= '0;
        end
        ESPERA: begin
          // A result arriving on the last allowed cycle still wins over the timeout.
          if (LED) begin
            r_pronto <= 1'b1;
            r_estado <= LIBERA;
            r_tempo  <= '0;
          end else if (w_tempo_esgotado) begin
            r_estado <= ERRO;
            r_erro   <= 1'b1;
          end else begin
            r_tempo <= r_tempo + TW'(1);
          end
        end
        LIBERA: begin
          if (!LED) begin
            r_pronto   <= 1'b0;
            r_contagem <= w_contagem_inc;
            if (w_ultimo) begin
              r_estado    <= FIM;
              r_concluido <= 1'b1;
            end else begin
              r_x      <= r_x + passo;
              r_estado <= INICIA;
              r_inicio <= 1'b1;
            end
          end else if (w_tempo_esgotado) begin
            r_pronto <= 1'b0;
            r_estado <= ERRO;
            r_erro   <= 1'b1;
          end else begin
            r_tempo <= r_tempo + TW'(1);
          end
        end
        FIM: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
        ERRO: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
        default: begin
          r_estado  <= OCIOSO;
          r_ocupado <= 1'b0;
        end
      endcase
    end
  end

  banco_resultados #(
    .W        (W),
    .N_PONTOS (N_PONTOS)
  ) u_banco (
    .ck            (ck),
    .i_escreve     (w_escreve),
    .i_end_escrita (r_contagem[AW-1:0]),
    .i_dado        (Resultado),
    .i_end_leitura (indice_leitura),
    .o_dado        (w_dado_banco)
  );

  // Entries not yet written in this sweep read as zero, hiding stale data.
  assign dado_leitura = ({1'b0, indice_leitura} < r_contagem) ? w_dado_banco : '0;

  assign inicio    = r_inicio;
  assign pronto    = r_pronto;
  assign ocupado   = r_ocupado;
  assign concluido = r_concluido;
  assign erro      = r_erro;
  assign contagem  = r_contagem;
  assign X         = r_x;
  assign A         = r_a;
  assign B         = r_b;
  assign C         = r_c;

endmodule
